// File: rtl/modulo_unit.sv
`default_nettype none
// ============================================================================
//  Module   : modulo_unit
//  Purpose  : Sequential unsigned modulo engine (restoring shift-subtract).
//             Responder side of the modulo_start/modulo_ready handshake used
//             by the GCD datapath; returns op_a mod op_b.
//  Ports    : clk            - system clock (rising edge)
//             rst_i          - synchronous reset, active-high
//             modulo_start_i - request strobe (sampled in IDLE or DONE)
//             op_a_i         - dividend, captured on acceptance
//             op_b_i         - divisor, captured on acceptance
//             res_o          - registered remainder, held until next completion
//             modulo_ready_o - one-cycle completion pulse
//             busy_o         - high while the shift-subtract loop runs
//             div_zero_o     - last request had a zero divisor (res_o = op_a)
//  Options  : MODULO_EARLY_EXIT_EN - when defined, requests with
//             op_a < op_b (nonzero op_b) complete without iterating.
//  Revision : 1.0 - initial release
// ============================================================================
module modulo_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             modulo_start_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             modulo_ready_o,
  output logic             busy_o,
  output logic             div_zero_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0]       c_IDLE     = 2'd0;
  localparam logic [1:0]       c_CALC     = 2'd1;
  localparam logic [1:0]       c_DONE     = 2'd2;
  localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             r_dz;

  logic             w_accept;
  logic             w_bzero;
  logic             w_early;
  logic             w_short;
  logic [WIDTH:0]   w_rem_next;
  logic [WIDTH:0]   w_rem_sel;
  logic             w_unused;
  logic             w_ready;
  logic             w_busy;

  // Requests are only taken when no iteration is in flight.
  assign w_accept = modulo_start_i && ((r_state == c_IDLE) || (r_state == c_DONE));
  assign w_bzero  = (op_b_i == '0);

`ifdef MODULO_EARLY_EXIT_EN
  assign w_early = !w_bzero && (op_a_i < op_b_i);
`else
  assign w_early = 1'b0;
`endif

  // Requests whose answer is op_a itself skip the iteration loop.
  assign w_short = w_bzero || w_early;

  // Partial remainder is kept WIDTH+1 bits wide so the shifted-in bit is never
  // lost before the compare; after a conditional subtract it is always below
  // the divisor, so the top bit of the selected value is always zero.
  assign w_rem_next = {r_rem, r_dvd[WIDTH-1]};
  assign w_rem_sel  = (w_rem_next >= {1'b0, r_dvs}) ? (w_rem_next - {1'b0, r_dvs})
                                                    : w_rem_next;
  assign w_unused   = w_rem_sel[WIDTH];

  // State register
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE, c_DONE: begin
        if (w_accept) begin
          w_state_next = w_short ? c_DONE : c_CALC;
        end else begin
          w_state_next = c_IDLE;
        end
      end
      c_CALC: begin
        if (r_cnt == '0) begin
          w_state_next = c_DONE;
        end
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      c_CALC:  w_busy  = 1'b1;
      c_DONE:  w_ready = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_rem <= '0;
      r_dvd <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_res <= '0;
      r_dz  <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= op_a_i;
      r_dvs <= op_b_i;
      r_rem <= '0;
      r_cnt <= c_CNT_INIT;
      r_dz  <= w_bzero;
      if (w_short) begin
        r_res <= op_a_i;
      end
    end else if (r_state == c_CALC) begin
      r_rem <= w_rem_sel[WIDTH-1:0];
      r_dvd <= r_dvd << 1;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        r_res <= w_rem_sel[WIDTH-1:0];
      end
    end
  end

  assign res_o          = r_res;
  assign div_zero_o     = r_dz;
  assign modulo_ready_o = w_ready;
  assign busy_o         = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_modulo_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_modulo_unit
//  Purpose  : Self-checking bench for modulo_unit (WIDTH=16): vector table,
//             hand-written handshake/reset sequences, randomized requests
//             against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_modulo_unit;

  localparam int WIDTH = 16;
  localparam int FULL_LAT = WIDTH + 1;
`ifdef MODULO_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             modulo_start_i = 1'b0;
  logic [WIDTH-1:0] op_a_i = '0;
  logic [WIDTH-1:0] op_b_i = '0;
  logic [WIDTH-1:0] res_o;
  logic             modulo_ready_o;
  logic             busy_o;
  logic             div_zero_o;

  int n_chk  = 0;
  int n_pass = 0;

  modulo_unit #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst_i          (rst_i),
    .modulo_start_i (modulo_start_i),
    .op_a_i         (op_a_i),
    .op_b_i         (op_b_i),
    .res_o          (res_o),
    .modulo_ready_o (modulo_ready_o),
    .busy_o         (busy_o),
    .div_zero_o     (div_zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             dz;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: plain arithmetic.
  function automatic logic [WIDTH-1:0] model_res(input logic [WIDTH-1:0] a, b);
    return (b == 0) ? a : (a % b);
  endfunction

  function automatic int model_lat(input logic [WIDTH-1:0] a, b);
    if (b == 0) return 1;
    if (EARLY && (a < b)) return 1;
    return FULL_LAT;
  endfunction

  // Issue one request and wait for its ready pulse. With b2b=1 the caller is
  // already at the sampling point of a DONE cycle and the start is presented
  // there. lat = cycles from acceptance to ready (0 = timeout).
  task automatic run_req(input logic [WIDTH-1:0] a, b, input bit b2b,
                         output int lat, output int nbusy,
                         output logic [WIDTH-1:0] res, output logic dz);
    if (!b2b) @(negedge clk);
    modulo_start_i = 1'b1;
    op_a_i = a;
    op_b_i = b;
    @(posedge clk);
    #1;
    modulo_start_i = 1'b0;
    op_a_i = WIDTH'($urandom);
    op_b_i = WIDTH'($urandom);
    lat = 0;
    nbusy = 0;
    res = 'x;
    dz = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy_o) nbusy++;
      if (modulo_ready_o) begin
        lat = n;
        res = res_o;
        dz = div_zero_o;
        break;
      end
    end
  endtask

  initial begin
    vec_t             vecs[$];
    int               lat, nbusy, rdy_cnt, first_rdy;
    logic [WIDTH-1:0] res, ea, eb;
    logic             dz;

    vecs.push_back('{a: 16'd0,     b: 16'd5,      res: 16'd0,     dz: 1'b0});
    vecs.push_back('{a: 16'd5,     b: 16'd5,      res: 16'd0,     dz: 1'b0});
    vecs.push_back('{a: 16'd3,     b: 16'd10,     res: 16'd3,     dz: 1'b0});
    vecs.push_back('{a: 16'hFFFF,  b: 16'h8000,   res: 16'h7FFF,  dz: 1'b0});
    vecs.push_back('{a: 16'h8000,  b: 16'd3,      res: 16'd2,     dz: 1'b0});
    vecs.push_back('{a: 16'd0,     b: 16'd0,      res: 16'd0,     dz: 1'b1});
    vecs.push_back('{a: 16'hFFFF,  b: 16'd0,      res: 16'hFFFF,  dz: 1'b1});
    vecs.push_back('{a: 16'd12345, b: 16'd1,      res: 16'd0,     dz: 1'b0});
    vecs.push_back('{a: 16'd1,     b: 16'hFFFF,   res: 16'd1,     dz: 1'b0});
    vecs.push_back('{a: 16'd60000, b: 16'd257,    res: 16'd119,   dz: 1'b0});

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("reset res_o", res_o, 0);
    check("reset ready", modulo_ready_o, 0);
    check("reset busy", busy_o, 0);
    check("reset div_zero", div_zero_o, 0);

    // 48 mod 18: full-latency path with busy window, result hold.
    run_req(16'd48, 16'd18, 1'b0, lat, nbusy, res, dz);
    check("48%18 latency", lat, FULL_LAT);
    check("48%18 busy cycles", nbusy, 16);
    check("48%18 res", res, 12);
    check("48%18 dz", dz, 0);
    rdy_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (modulo_ready_o) rdy_cnt++;
    end
    check("48%18 res held c20", res_o, 12);
    check("48%18 single ready", rdy_cnt, 0);

    // Back-to-back request accepted in the DONE cycle.
    run_req(16'hFFFF, 16'd1, 1'b0, lat, nbusy, res, dz);
    check("FFFF%1 res", res, 0);
    run_req(16'hFFFF, 16'hFFFF, 1'b1, lat, nbusy, res, dz);
    check("b2b FFFF%FFFF res", res, 0);
    check("b2b ready spacing", lat, FULL_LAT);

    // Zero divisor, then a normal request clears div_zero.
    run_req(16'd5, 16'd0, 1'b0, lat, nbusy, res, dz);
    check("5%0 latency", lat, 1);
    check("5%0 res", res, 5);
    check("5%0 dz", dz, 1);
    run_req(16'd9, 16'd4, 1'b0, lat, nbusy, res, dz);
    check("9%4 res", res, 1);
    check("9%4 dz", dz, 0);

    // Start during CALC is ignored.
    @(negedge clk);
    modulo_start_i = 1'b1; op_a_i = 16'd100; op_b_i = 16'd7;
    @(posedge clk);
    #1 modulo_start_i = 1'b0;
    first_rdy = 0;
    rdy_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 5) begin modulo_start_i = 1'b1; op_a_i = 16'd3; op_b_i = 16'd2; end
      if (n == 6) modulo_start_i = 1'b0;
      if (modulo_ready_o) begin
        rdy_cnt++;
        if (first_rdy == 0) begin
          first_rdy = n;
          check("100%7 res", res_o, 2);
        end
      end
    end
    check("100%7 latency", first_rdy, FULL_LAT);
    check("100%7 one ready", rdy_cnt, 1);

    // Reset mid-CALC discards the computation.
    @(negedge clk);
    modulo_start_i = 1'b1; op_a_i = 16'd1000; op_b_i = 16'd33;
    @(posedge clk);
    #1 modulo_start_i = 1'b0;
    rdy_cnt = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (modulo_ready_o) rdy_cnt++;
      if (n == 8) rst_i = 1'b1;
    end
    @(negedge clk);
    rst_i = 1'b0;
    check("mid-reset res_o", res_o, 0);
    check("mid-reset busy", busy_o, 0);
    check("mid-reset ready", modulo_ready_o, 0);
    check("mid-reset dz", div_zero_o, 0);
    repeat (30) begin
      @(negedge clk);
      if (modulo_ready_o) rdy_cnt++;
    end
    check("mid-reset no ready", rdy_cnt, 0);
    run_req(16'd1000, 16'd33, 1'b0, lat, nbusy, res, dz);
    check("1000%33 res", res, 10);
    check("1000%33 latency", lat, FULL_LAT);

    // op_a < op_b: latency depends on build, result does not.
    run_req(16'd7, 16'd9, 1'b0, lat, nbusy, res, dz);
    check("7%9 res", res, 7);
    check("7%9 latency", lat, EARLY ? 1 : FULL_LAT);

    // Vector table.
    foreach (vecs[i]) begin
      run_req(vecs[i].a, vecs[i].b, 1'b0, lat, nbusy, res, dz);
      check($sformatf("vec%0d res", i), res, vecs[i].res);
      check($sformatf("vec%0d dz", i), dz, vecs[i].dz);
      check($sformatf("vec%0d latency", i), lat, model_lat(vecs[i].a, vecs[i].b));
    end

    // Randomized requests; some back-to-back, mixed divisor ranges.
    for (int i = 0; i < 80; i++) begin
      ea = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: eb = WIDTH'($urandom_range(0, 3));
        1: eb = WIDTH'($urandom_range(0, 255));
        default: eb = WIDTH'($urandom);
      endcase
      run_req(ea, eb, (i > 0) && ($urandom_range(0, 1) == 1), lat, nbusy, res, dz);
      check($sformatf("rnd%0d %0d%%%0d res", i, ea, eb), res, model_res(ea, eb));
      check($sformatf("rnd%0d dz", i), dz, (eb == 0));
      check($sformatf("rnd%0d latency", i), lat, model_lat(ea, eb));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/modulo_unit.md
Name: modulo_unit

Overview:
- Sequential unsigned modulo engine (restoring shift-subtract); responder side of the modulo_start/modulo_ready handshake driven by the GCD datapath and controller.
- Datapath presents two operands plus a start pulse; the block returns op_a mod op_b with a one-cycle ready pulse.
- Sits inside the ALU; each Euclid iteration issues one request.

Parameters:
- WIDTH, 16, operand/result width in bits.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- modulo_start_i  in  1  request strobe; sampled only in IDLE or DONE.
- op_a_i  in  WIDTH  dividend, unsigned; captured when a request is accepted.
- op_b_i  in  WIDTH  divisor, unsigned; captured when a request is accepted.
- res_o  out  WIDTH  remainder, registered; held until the next completion.
- modulo_ready_o  out  1  one-cycle completion pulse; res_o is valid in that cycle.
- busy_o  out  1  high while in CALC.
- div_zero_o  out  1  high with res_o when the last request had op_b == 0; held with res_o.

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, res_o=0, modulo_ready_o=0, busy_o=0, div_zero_o=0, internal remainder, dividend shadow, divisor and counter = 0. Reset has priority over everything, including mid-CALC; the in-flight result is discarded and no ready pulse is produced.
- States: IDLE, CALC, DONE.
- IDLE: modulo_start_i=1 accepts the request.
  - Latch op_a_i into the dividend shadow and op_b_i into the divisor; clear the remainder; set counter=WIDTH-1.
  - op_b_i==0 -> DONE with res_o=op_a_i, div_zero_o=1.
  - Otherwise -> CALC with div_zero_o=0.
- CALC: one bit per cycle, MSB first.
  - rem_next = {rem[WIDTH-1:0], dividend[WIDTH-1]} (WIDTH+1 bits, no overflow loss).
  - dividend shifts left by 1.
  - If rem_next >= divisor then rem = rem_next - divisor, else rem = rem_next.
  - counter decrements. When counter==0 is processed, go to DONE and load res_o = final rem[WIDTH-1:0].
- DONE: lasts exactly one cycle with modulo_ready_o=1.
  - modulo_start_i=1 in DONE is accepted with the same rules as IDLE (back-to-back requests, no bubble).
  - Otherwise -> IDLE.
- Latency: with the request accepted at the edge ending cycle 0, CALC occupies cycles 1..WIDTH and modulo_ready_o=1 in cycle WIDTH+1 (cycle 17 for WIDTH=16). Divisor zero: ready in cycle 1.
- modulo_start_i during CALC is ignored; there is no queueing, busy_o stays 1, and the captured operands are unaffected.
- Operand inputs may change freely after acceptance.
- modulo_ready_o is never high in two consecutive cycles unless back-to-back requests are accepted in DONE.
- Results: op_a < op_b gives res=op_a. op_a == op_b gives res=0. op_a = 0 gives res=0.

Optional Feature:
- Macro: MODULO_EARLY_EXIT_EN.
- Defined: at acceptance, if op_b_i != 0 and op_a_i < op_b_i, skip CALC. Go directly to DONE with res_o=op_a_i and div_zero_o=0; ready in cycle 1.
- Not defined: every nonzero-divisor request takes the full WIDTH-cycle CALC path; results are identical in both builds, only latency differs.

Test Plan:
- op_a=48, op_b=18, start pulse in cycle 0 -> busy_o=1 in cycles 1..16; modulo_ready_o=1 only in cycle 17, res_o=12, div_zero_o=0; res_o still 12 in cycle 20.
- op_a=0xFFFF, op_b=1, then (DONE-cycle start) op_a=0xFFFF, op_b=0xFFFF -> res_o=0 then res_o=0; second ready exactly 17 cycles after the first.
- op_a=5, op_b=0 -> ready in cycle 1, res_o=5, div_zero_o=1; a following op_a=9, op_b=4 -> res_o=1, div_zero_o=0.
- op_a=100, op_b=7 accepted; start with op_a=3, op_b=2 pulsed in cycle 5 -> ignored; ready in cycle 17 with res_o=2, and no further ready pulse.
- op_a=1000, op_b=33 accepted; rst_i=1 in cycle 8 -> cycle 9: state IDLE, all outputs 0, no ready pulse ever; a new request op_a=1000, op_b=33 -> res_o=10 after 17 cycles.
- op_a=7, op_b=9 -> with MODULO_EARLY_EXIT_EN: ready in cycle 1, res_o=7; without it: ready in cycle 17, res_o=7.
